// File: rtl/flit_pkg.sv
// Shared widths, FSM/FIFO entry types and the Hamming(7,4) encoder for the flit tx path.
// FLIT_TX_ERR_INJ_EN adds per-entry error-injection fields to fifo_entry_t.
package flit_pkg;
   localparam int FLIT_W = 11;
   localparam int ADDR_W = 4;
   localparam int CW_W   = 7;
   localparam int DATA_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_REQ_HI,
      ST_REQ_LO
   } tx_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] payload;
`ifdef FLIT_TX_ERR_INJ_EN
      logic              err_en;
      logic [2:0]        err_pos;
`endif
   } fifo_entry_t;

   // d1..d4 = d[0..3]; codeword laid out {d4,d3,d2,p4,d1,p2,p1}
   function automatic logic [CW_W-1:0] hamming74_enc(input logic [DATA_W-1:0] d);
      logic p1, p2, p4;
      p1 = d[0] ^ d[1] ^ d[3];
      p2 = d[0] ^ d[2] ^ d[3];
      p4 = d[1] ^ d[2] ^ d[3];
      return {d[3], d[2], d[1], p4, d[0], p2, p1};
   endfunction
endpackage

// File: rtl/flit_tx_fifo.sv
// Circular-buffer FIFO for pending flit entries; registered pointers, head visible combinationally.
// Caller guarantees no write when full and no read when empty.
module flit_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [W-1:0]           wr_dat,
   input  logic                   rd_en,
   output logic [W-1:0]           rd_dat,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
   end

   assign rd_dat = mem_q[rd_ptr_q];
   assign count  = count_q;
endmodule

// File: rtl/flit_tx_bridge.sv
// Buffers (dest, payload) entries, Hamming-encodes them and drives a four-phase bundled-data flit link.
// tx_req rises SETUP_CYC+1 cycles after acceptance; in_ready drops when the FIFO is full. Optional FLIT_TX_ERR_INJ_EN.
module flit_tx_bridge
   import flit_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int SETUP_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_dest,
   input  logic [DATA_W-1:0] in_payload,
`ifdef FLIT_TX_ERR_INJ_EN
   input  logic              in_err_en,
   input  logic [2:0]        in_err_pos,
`endif
   output logic              tx_req,
   input  logic              tx_ack,
   output logic [FLIT_W-1:0] tx_data,
   output logic              busy,
   output logic [15:0]       tx_count
);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam int SC_W  = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;
   localparam int ENT_W = $bits(fifo_entry_t);

   tx_state_t         state_q;
   logic [SC_W-1:0]   setup_cnt_q;
   logic              tx_req_q, in_ready_q, ack_meta_q, ack_s_q;
   logic [FLIT_W-1:0] tx_data_q;
   logic [15:0]       tx_count_q;

   fifo_entry_t       wr_entry, head;
   logic [ENT_W-1:0]  head_dat;
   logic [CNT_W-1:0]  fifo_count, count_d;
   logic              wr_en, pop;
   logic [CW_W-1:0]   cw;

   always_comb begin
      wr_entry         = '0;
      wr_entry.dest    = in_dest;
      wr_entry.payload = in_payload;
`ifdef FLIT_TX_ERR_INJ_EN
      wr_entry.err_en  = in_err_en;
      wr_entry.err_pos = in_err_pos;
`endif
   end

   assign wr_en = in_valid && in_ready_q;

   flit_tx_fifo #(.DEPTH(DEPTH), .W(ENT_W)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en),
      .wr_dat (wr_entry),
      .rd_en  (pop),
      .rd_dat (head_dat),
      .count  (fifo_count)
   );

   assign head = head_dat;

   // Loads happen only with tx_req low and ack_s low, so tx_data is stable across the handshake
   always_comb begin
      pop = 1'b0;
      if (fifo_count != '0) begin
         if (state_q == ST_IDLE) pop = 1'b1;
         else if (state_q == ST_REQ_LO && !ack_s_q) pop = 1'b1;
      end
   end

   always_comb begin
      count_d = fifo_count;
      if (wr_en && !pop) count_d = fifo_count + 1'b1;
      else if (!wr_en && pop) count_d = fifo_count - 1'b1;
   end

   always_comb begin
      cw = hamming74_enc(head.payload);
`ifdef FLIT_TX_ERR_INJ_EN
      if (head.err_en && head.err_pos != 3'd7) cw[head.err_pos] = ~cw[head.err_pos];
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         setup_cnt_q <= '0;
         tx_req_q    <= 1'b0;
         tx_data_q   <= '0;
         tx_count_q  <= '0;
         in_ready_q  <= 1'b0;
         ack_meta_q  <= 1'b0;
         ack_s_q     <= 1'b0;
      end else begin
         ack_meta_q <= tx_ack;
         ack_s_q    <= ack_meta_q;
         in_ready_q <= (count_d < CNT_W'(DEPTH));
         if (pop) begin
            tx_data_q   <= {head.dest, cw};
            setup_cnt_q <= '0;
         end
         case (state_q)
            ST_IDLE: begin
               if (pop) state_q <= ST_SETUP;
            end
            ST_SETUP: begin
               if (setup_cnt_q == SC_W'(SETUP_CYC - 1)) begin
                  tx_req_q <= 1'b1;
                  state_q  <= ST_REQ_HI;
               end else begin
                  setup_cnt_q <= setup_cnt_q + 1'b1;
               end
            end
            ST_REQ_HI: begin
               if (ack_s_q) begin
                  tx_req_q   <= 1'b0;
                  tx_count_q <= tx_count_q + 16'd1;
                  state_q    <= ST_REQ_LO;
               end
            end
            ST_REQ_LO: begin
               if (!ack_s_q) state_q <= pop ? ST_SETUP : ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign tx_req   = tx_req_q;
   assign tx_data  = tx_data_q;
   assign tx_count = tx_count_q;
   assign in_ready = in_ready_q;
   assign busy     = (fifo_count != '0) || (state_q != ST_IDLE);
endmodule

// File: tb/tb_flit_tx_bridge.sv
// Bench for flit_tx_bridge: vector table plus hand-written backpressure, random-ack and reset sequences.
`timescale 1ns/1ps
module tb_flit_tx_bridge;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [3:0]  in_dest, in_payload;
   logic        tx_req, tx_ack, busy;
   logic [10:0] tx_data;
   logic [15:0] tx_count;
`ifdef FLIT_TX_ERR_INJ_EN
   logic        in_err_en;
   logic [2:0]  in_err_pos;
`endif

   always #5 clk = ~clk;

   flit_tx_bridge #(.DEPTH(DEPTH), .SETUP_CYC(1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_dest    (in_dest),
      .in_payload (in_payload),
`ifdef FLIT_TX_ERR_INJ_EN
      .in_err_en  (in_err_en),
      .in_err_pos (in_err_pos),
`endif
      .tx_req     (tx_req),
      .tx_ack     (tx_ack),
      .tx_data    (tx_data),
      .busy       (busy),
      .tx_count   (tx_count)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Node model: acknowledges request edges after a fixed or random number of cycles
   bit ack_hold = 1'b0;
   bit ack_rand = 1'b0;
   int ack_dly  = 3;
   initial begin
      int nd;
      tx_ack = 1'b0;
      forever begin
         @(posedge clk);
         if (tx_req && !tx_ack && !ack_hold) begin
            nd = ack_rand ? int'($urandom_range(0, 10)) : ack_dly;
            repeat (nd) @(posedge clk);
            #1 tx_ack = 1'b1;
         end else if (!tx_req && tx_ack) begin
            nd = ack_rand ? int'($urandom_range(0, 10)) : ack_dly;
            repeat (nd) @(posedge clk);
            #1 tx_ack = 1'b0;
         end
      end
   end

   // Independent view of the DUT's synchronized ack
   logic bs1, bs2;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bs1 <= 1'b0;
         bs2 <= 1'b0;
      end else begin
         bs1 <= tx_ack;
         bs2 <= bs1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   logic [10:0] exp_q[$];
   int n_rise = 0, n_fall = 0, n_unstable = 0, rise_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Hamming code by bit position 1..7: data at 3,5,6,7, parity at 1,2,4
   function automatic logic [10:0] model_flit(input logic [3:0] dest, input logic [3:0] pl);
      logic [7:1] c;
      c[3] = pl[0]; c[5] = pl[1]; c[6] = pl[2]; c[7] = pl[3];
      c[1] = c[3] ^ c[5] ^ c[7];
      c[2] = c[3] ^ c[6] ^ c[7];
      c[4] = c[5] ^ c[6] ^ c[7];
      return {dest, c[7:1]};
   endfunction

   task automatic monitor();
      logic        prev_req, prev_as;
      logic [10:0] prev_data, exp;
      prev_req = 1'b0; prev_as = 1'b0; prev_data = '0;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (tx_data !== prev_data && (prev_req || prev_as || tx_req)) n_unstable++;
            if (tx_req && !prev_req) begin
               rise_cyc = cyc;
               n_rise++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL sb_unexpected: flit 0x%0h sent, scoreboard empty", tx_data);
               end else begin
                  exp = exp_q.pop_front();
                  check("sb_flit", 32'(tx_data), 32'(exp));
               end
            end
            if (!tx_req && prev_req) n_fall++;
         end
         prev_req  = tx_req;
         prev_as   = bs2;
         prev_data = tx_data;
      end
   endtask

   task automatic push(input logic [3:0] d, input logic [3:0] p, input logic [10:0] exp_flit,
                       output int acc_cyc);
      int t;
      t = 0;
      acc_cyc = -1;
      @(negedge clk);
      in_valid = 1'b1; in_dest = d; in_payload = p;
      while (!in_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         check("push_timeout_in_ready", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
      end else begin
         exp_q.push_back(exp_flit);
         @(posedge clk);
         #1;
         acc_cyc = cyc;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      @(negedge clk);
      while ((busy || tx_req || tx_ack || bs2 || exp_q.size() != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check({name, "_idle"}, 32'(busy || tx_req || tx_ack || bs2), 32'd0);
   endtask

   typedef struct {
      logic [3:0]  dest;
      logic [3:0]  payload;
      logic [10:0] flit;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int acc, r0, f0, t, cnt_base;
      vecs[0] = '{4'h2, 4'b1011, 11'h155};
      vecs[1] = '{4'h0, 4'b0000, 11'h000};
      vecs[2] = '{4'h0, 4'b1111, 11'h07F};
      vecs[3] = '{4'h5, 4'b0001, 11'h287};
      vecs[4] = '{4'hF, 4'b1000, 11'h7CB};
      vecs[5] = '{4'hA, 4'b0110, 11'h533};

      rst_n = 1'b0; in_valid = 1'b0; in_dest = '0; in_payload = '0;
`ifdef FLIT_TX_ERR_INJ_EN
      in_err_en = 1'b0; in_err_pos = 3'd0;
`endif
      cnt_base = 0;
      fork monitor(); join_none

      repeat (3) @(negedge clk);
      check("rst_tx_req", 32'(tx_req), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_tx_count", 32'(tx_count), 0);
      rst_n = 1'b1;
      #1 check("in_ready_before_edge", 32'(in_ready), 0);
      @(posedge clk);
      #1 check("in_ready_after_rst", 32'(in_ready), 1);

      // Vector table: one flit at a time, fixed 3-cycle node ack
      for (int i = 0; i < 6; i++) begin
         r0 = n_rise;
         push(vecs[i].dest, vecs[i].payload, vecs[i].flit, acc);
         t = 0;
         while (n_rise == r0 && t < 100) begin
            @(negedge clk);
            t++;
         end
         check("req_latency", 32'(rise_cyc - acc), 32'd2);
         check("vec_tx_data", 32'(tx_data), 32'(vecs[i].flit));
         wait_idle("vec");
         check("vec_tx_count", 32'(tx_count), 32'(n_fall));
         check("vec_busy", 32'(busy), 0);
      end

      // Back-to-back 0000 / 1111 to dest 0
      r0 = n_rise; f0 = n_fall;
      push(4'h0, 4'b0000, 11'h000, acc);
      push(4'h0, 4'b1111, 11'h07F, acc);
      wait_idle("b2b");
      check("b2b_rises", 32'(n_rise - r0), 32'd2);
      check("b2b_falls", 32'(n_fall - f0), 32'd2);

      // Backpressure: node withholds ack, DEPTH queued plus one in flight
      ack_hold = 1'b1;
      r0 = n_rise;
      for (int i = 0; i < DEPTH + 1; i++)
         push(4'(i + 1), 4'(i + 3), model_flit(4'(i + 1), 4'(i + 3)), acc);
      @(negedge clk);
      check("bp_in_ready_full", 32'(in_ready), 0);
      check("bp_busy", 32'(busy), 1);
      in_valid = 1'b1; in_dest = 4'hE; in_payload = 4'h9;
      repeat (6) @(negedge clk);
      check("bp_in_ready_held", 32'(in_ready), 0);
      in_valid = 1'b0;
      ack_hold = 1'b0;
      wait_idle("bp");
      check("bp_delivered", 32'(n_rise - r0), 32'(DEPTH + 1));
      check("bp_in_ready_back", 32'(in_ready), 1);
      check("bp_tx_count", 32'(tx_count), 32'(n_fall));

      // Random flits with random ack delays; tx_data must stay put during handshakes
      ack_rand = 1'b1;
      r0 = n_rise;
      for (int i = 0; i < 100; i++) begin
         logic [3:0] d, p;
         d = 4'($urandom_range(0, 15));
         p = 4'($urandom_range(0, 15));
         push(d, p, model_flit(d, p), acc);
      end
      wait_idle("rand");
      check("rand_delivered", 32'(n_rise - r0), 32'd100);
      check("rand_tx_count", 32'(tx_count), 32'(n_fall));
      check("tx_data_stable", 32'(n_unstable), 0);
      ack_rand = 1'b0;

      // Reset while tx_req is high
      push(4'h3, 4'h5, model_flit(4'h3, 4'h5), acc);
      push(4'h4, 4'h6, model_flit(4'h4, 4'h6), acc);
      t = 0;
      while (!tx_req && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("req_before_rst", 32'(tx_req), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_tx_req", 32'(tx_req), 0);
      check("rst_async_busy", 32'(busy), 0);
      check("rst_async_tx_count", 32'(tx_count), 0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cnt_base = n_fall;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 32'(in_ready), 1);
      check("post_rst_busy", 32'(busy), 0);
      check("post_rst_tx_count", 32'(tx_count), 0);
      wait_idle("post_rst_settle");
      push(4'h7, 4'hC, model_flit(4'h7, 4'hC), acc);
      wait_idle("post_rst");
      check("post_rst_count1", 32'(tx_count), 32'(n_fall - cnt_base));

`ifdef FLIT_TX_ERR_INJ_EN
      in_err_en = 1'b1; in_err_pos = 3'd2;
      push(4'h0, 4'h0, 11'h004, acc);
      wait_idle("err_pos2");
      in_err_pos = 3'd7;
      push(4'h0, 4'h0, 11'h000, acc);
      wait_idle("err_pos7");
      in_err_en = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/flit_tx_bridge.md
# flit_tx_bridge

Clocked transmitter for the node's 11-bit four-phase bundled-data flit channel. Accepts (destination, 4-bit payload) pairs on a valid/ready interface and buffers them in a small FIFO. Each entry is Hamming(7,4)-encoded and driven as one flit `{dest[3:0], codeword[6:0]}` into a node input port (`in1`..`in4`). It is the injecting end of the link whose receiving end is the node's input arbiter, edu and path computation.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- SETUP_CYC, 1: cycles `tx_data` is held stable before `tx_req` rises (bundling margin); ≥1.

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  entry offered
- in_ready  output  1  entry accepted when `in_valid && in_ready`
- in_dest  input  4  destination node IP
- in_payload  input  4  raw data nibble
- tx_req  output  1  four-phase request to node
- tx_ack  input  1  four-phase acknowledge from node; asynchronous to clk
- tx_data  output  11  bundled data: [10:7]=dest, [6:0]=codeword
- busy  output  1  FIFO non-empty or handshake in progress
- tx_count  output  16  completed handshakes, wraps modulo 2^16

## Operation
- Encoding uses d1..d4 = payload[0..3]:
  - p1=d1^d2^d4, p2=d1^d3^d4, p4=d2^d3^d4.
  - cw[6:0] = {d4,d3,d2,p4,d1,p2,p1}.
- `tx_ack` passes through a 2-flop synchronizer, producing ack_s; only ack_s is used.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, load encoded flit into tx_data, go to SETUP.
  - SETUP: hold for SETUP_CYC cycles, then assert tx_req and go to REQ_HI.
  - REQ_HI: wait for ack_s=1, then deassert tx_req, increment tx_count, go to REQ_LO.
  - REQ_LO: wait for ack_s=0. If FIFO non-empty, pop and load the next flit and go to SETUP; else go to IDLE.
- tx_data changes only in IDLE/REQ_LO load cycles, i.e. never while tx_req=1 or ack_s=1.
- FIFO behaviour:
  - Write on accepted entry, pop on load.
  - Simultaneous write and pop is allowed; count is unchanged.
  - Full: in_ready=0; in_valid is ignored.
- in_ready is registered: next value = (count_next < DEPTH).
- busy = (count≠0) || (state≠IDLE).

## Timing
- Reset values: tx_req=0, tx_data=0, in_ready=0, busy=0, tx_count=0, FSM=IDLE, FIFO empty, synchronizer flops=0. in_ready becomes 1 on the first clock edge after rst_n deasserts.
- Latency with the bridge idle, entry accepted at edge N:
  - load at edge N+1;
  - tx_req=1 after edge N+1+SETUP_CYC (N+2 at default).
- ack path: ack rise visible as ack_s two edges later, and tx_req falls on the following edge. Ack fall behaves the same way.
- Minimum flit period with instant node ack: SETUP_CYC + 6 cycles.
- Reset mid-handshake: tx_req drops immediately and queued entries are lost. The node must be reset in the same reset domain; no recovery of partial handshakes.
- tx_count wraps from 0xFFFF to 0x0000 without a flag.

## Configuration
- FLIT_TX_ERR_INJ_EN: when defined, adds two inputs:
  - in_err_en (1)
  - in_err_pos (3)
  
  Both are captured with the entry in the FIFO. If in_err_en=1, codeword bit in_err_pos (0..6) is inverted at load; a pos of 7 means no flip. Used to exercise the edu.
- Without the macro: ports and FIFO bits are absent and codewords are always clean.

## Structure
- Package flit_pkg:
  - FLIT_W=11, ADDR_W=4, CW_W=7
  - function hamming74_enc
  - typedef of the tx FSM state enum
  - typedef of the FIFO entry struct
- Submodule flit_tx_fifo: parameterized DEPTH, entry struct width, count output, same clk/rst_n.
- Synchronizer inline (2 flops); FSM and encoder in top.

## Test plan
- Reset, then dest=4'b0010, payload=4'b1011, node acks after 3 cycles → tx_data=11'h155; tx_req rises at N+2; one handshake completes; tx_count=1; busy returns to 0.
- payload 0000 and 1111 to dest 0 → tx_data=11'h000 then 11'h07F, sent in order, with tx_req returning low between them.
- Hold tx_ack=0, push DEPTH+2 entries → in_ready=0 after the FIFO holds DEPTH entries plus one in flight. Release ack → all DEPTH+1 flits delivered in order and in_ready returns to 1.
- Monitor tx_data across 100 random flits with random ack delays (0–10 cycles) → tx_data never changes while tx_req|ack_s is high.
- Assert rst_n=0 while tx_req=1 → tx_req=0 asynchronously; after release, busy=0, tx_count=0 and in_ready=1 one edge later.
- With FLIT_TX_ERR_INJ_EN: payload 0000, err_en=1, err_pos=2 → codeword 7'h04. With err_pos=7 → 7'h00.
